// File: rtl/detector_jogada.sv
// detector_jogada: debounced 9-button move detector for a tic-tac-toe board.
// Synchronizes the raw button levels, filters presses and releases over
// DEBOUNCE_CYCLES stable cycles, and reports a single accepted move per press.
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous reset, active-low
//   botoes     - raw button levels, bit k is cell k+1
//   habilita   - high when the game accepts a move
//   jogada     - one-hot code of the last accepted move
//   jogada_idx - 1..9 index of the last accepted move, 0 = none
//   tem_jogada - one-cycle strobe for a newly accepted move
//   multipla   - one-cycle strobe for a rejected multi-button press
//   db_estado  - current FSM state code
module detector_jogada #(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] botoes,
    input  logic       habilita,
    output logic [8:0] jogada,
    output logic [3:0] jogada_idx,
    output logic       tem_jogada,
    output logic       multipla,
    output logic [3:0] db_estado
);

    localparam int unsigned N_BOTOES = 9;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LIMITE   = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

    typedef enum logic [3:0] {
        ESPERA         = 4'd0,
        FILTRA         = 4'd1,
        VALIDA         = 4'd2,
        AGUARDA_SOLTAR = 4'd3,
        FILTRA_SOLTURA = 4'd4
    } estado_t;

    logic [N_BOTOES-1:0] sinc_meta;
    logic [N_BOTOES-1:0] sinc;

    estado_t             estado;
    estado_t             estado_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                cnt_fim;
    logic [N_BOTOES-1:0] padrao;
    logic [N_BOTOES-1:0] padrao_nxt;
    logic [N_BOTOES-1:0] jogada_nxt;
    logic [IDX_W-1:0]    jogada_idx_nxt;
    logic                tem_jogada_nxt;
    logic                multipla_nxt;
    logic [IDX_W-1:0]    idx_padrao;
    logic                padrao_multi;

    // Two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_meta <= '0;
            sinc      <= '0;
        end else begin
            sinc_meta <= botoes;
            sinc      <= sinc_meta;
        end
    end

    // Filter counter step; the exit compare fires before the counter can wrap
    assign cnt_inc = cnt + CNT_W'(1);
    assign cnt_fim = (cnt_inc >= CNT_W'(LIMITE));

    // Clearing the lowest set bit leaves something only if two or more bits were set
    assign padrao_multi = ((padrao & (padrao - N_BOTOES'(1))) != '0);

    // 1-based position of the set bit; only used when the pattern is one-hot
    always_comb begin
        idx_padrao = '0;
        for (int unsigned i = 0; i < N_BOTOES; i++) begin
            if (padrao[i]) begin
                idx_padrao = IDX_W'(i + 1);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        estado_nxt     = estado;
        cnt_nxt        = cnt;
        padrao_nxt     = padrao;
        jogada_nxt     = jogada;
        jogada_idx_nxt = jogada_idx;
        tem_jogada_nxt = 1'b0;
        multipla_nxt   = 1'b0;

        case (estado)
            ESPERA: begin
                if (sinc != '0) begin
                    padrao_nxt = sinc;
                    cnt_nxt    = '0;
                    estado_nxt = FILTRA;
                end
            end

            FILTRA: begin
                if (sinc == '0) begin
                    cnt_nxt    = '0;
                    estado_nxt = ESPERA;
                end else if (sinc != padrao) begin
                    // Pattern changed mid-filter: restart on the new one
                    padrao_nxt = sinc;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_fim) begin
                        estado_nxt = VALIDA;
                    end
                end
            end

            VALIDA: begin
                estado_nxt = AGUARDA_SOLTAR;
                if (padrao_multi) begin
                    multipla_nxt = 1'b1;
                end else if (habilita) begin
                    tem_jogada_nxt = 1'b1;
                    jogada_nxt     = padrao;
                    jogada_idx_nxt = idx_padrao;
                end
            end

            AGUARDA_SOLTAR: begin
                if (sinc == '0) begin
                    cnt_nxt    = '0;
                    estado_nxt = FILTRA_SOLTURA;
                end
            end

            FILTRA_SOLTURA: begin
                if (sinc != '0) begin
                    estado_nxt = AGUARDA_SOLTAR;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_fim) begin
                        estado_nxt = ESPERA;
                    end
                end
            end

            default: begin
                cnt_nxt    = '0;
                estado_nxt = ESPERA;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= ESPERA;
            cnt        <= '0;
            padrao     <= '0;
            jogada     <= '0;
            jogada_idx <= '0;
            tem_jogada <= 1'b0;
            multipla   <= 1'b0;
        end else begin
            estado     <= estado_nxt;
            cnt        <= cnt_nxt;
            padrao     <= padrao_nxt;
            jogada     <= jogada_nxt;
            jogada_idx <= jogada_idx_nxt;
            tem_jogada <= tem_jogada_nxt;
            multipla   <= multipla_nxt;
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios plus random button segments,
// checked by a run-length reference model feeding a strobe scoreboard.
module tb_detector_jogada;

    localparam int unsigned DEB = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] botoes = '0;
    logic       habilita = 1'b1;
    logic [8:0] jogada;
    logic [3:0] jogada_idx;
    logic       tem_jogada;
    logic       multipla;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    detector_jogada #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock      (clock),
        .reset      (reset),
        .botoes     (botoes),
        .habilita   (habilita),
        .jogada     (jogada),
        .jogada_idx (jogada_idx),
        .tem_jogada (tem_jogada),
        .multipla   (multipla),
        .db_estado  (db_estado)
    );

    typedef struct {
        int unsigned cyc;
        logic [1:0]  kind;   // 2'b10 accepted move, 2'b01 multi-press
        logic [8:0]  jog;
        logic [3:0]  idx;
    } ev_t;

    ev_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned n_tem = 0;
    logic [8:0]  exp_jog = '0;
    logic [3:0]  exp_idx = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] pos_of(input logic [8:0] p);
        for (int k = 0; k < 9; k++) begin
            if (p[k]) return 4'(k + 1);
        end
        return 4'd0;
    endfunction

    // Reference model: the FSM sees the input two edges late; a move is
    // decided when the same nonzero value has been seen for DEB consecutive
    // cycles while armed, and re-arming needs DEB consecutive zero cycles
    // after the decision cycle.
    logic [8:0] h1 = '0, h2 = '0;
    bit         armed = 1'b1;
    logic [8:0] run_val = '0;
    int         run_len = 0;
    int         zeros = 0;
    bit         pend = 1'b0;
    logic [8:0] pend_pat = '0;

    always @(posedge clock) begin
        logic [8:0] s;
        ev_t        ev;
        cyc++;
        if (!reset) begin
            h1 = '0; h2 = '0; armed = 1'b1; run_len = 0; zeros = 0; pend = 1'b0;
        end else begin
            s  = h2;
            h2 = h1;
            h1 = botoes;
            if (pend) begin
                pend  = 1'b0;
                armed = 1'b0;
                zeros = 0;
                ev.cyc = cyc;
                ev.jog = pend_pat;
                ev.idx = pos_of(pend_pat);
                if ($countones(pend_pat) > 1) begin
                    ev.kind = 2'b01;
                    sb.push_back(ev);
                end else if (habilita) begin
                    ev.kind = 2'b10;
                    sb.push_back(ev);
                end
            end else if (armed) begin
                if (s == '0) begin
                    run_len = 0;
                end else if (run_len > 0 && s == run_val) begin
                    run_len++;
                end else begin
                    run_val = s;
                    run_len = 1;
                end
                if (run_len == DEB) begin
                    pend     = 1'b1;
                    pend_pat = run_val;
                end
            end else begin
                if (s == '0) begin
                    zeros++;
                    if (zeros == DEB) begin
                        armed   = 1'b1;
                        run_len = 0;
                    end
                end else begin
                    zeros = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every strobe and tracks held outputs
    always @(negedge clock) begin
        ev_t ev;
        if (reset) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                ev = sb.pop_front();
                check("missed_strobe", 32'(ev.kind), 32'd0);
            end
            if (tem_jogada && multipla) check("strobe_exclusive", 32'd1, 32'd0);
            if (tem_jogada) n_tem++;
            if (tem_jogada || multipla) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 32'({tem_jogada, multipla}), 32'd0);
                end else begin
                    ev = sb.pop_front();
                    check("strobe_edge", cyc, ev.cyc);
                    check("strobe_kind", 32'({tem_jogada, multipla}), 32'(ev.kind));
                    if (ev.kind == 2'b10) begin
                        exp_jog = ev.jog;
                        exp_idx = ev.idx;
                    end
                end
            end
            check("jogada_hold", 32'(jogada), 32'(exp_jog));
            check("jogada_idx_hold", 32'(jogada_idx), 32'(exp_idx));
        end
    end

    task automatic hold(input logic [8:0] b, input logic h, input int unsigned n);
        repeat (n) begin
            @(negedge clock);
            botoes   = b;
            habilita = h;
        end
    endtask

    // Waits a bounded number of cycles for tem_jogada; returns the edge seen
    task automatic wait_tem(input int unsigned budget, output int unsigned seen);
        seen = 0;
        for (int i = 0; i < int'(budget); i++) begin
            @(negedge clock);
            if (tem_jogada && seen == 0) seen = cyc;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_jogada"}, 32'(jogada), 32'd0);
        check({tag, "_idx"}, 32'(jogada_idx), 32'd0);
        check({tag, "_tem"}, 32'(tem_jogada), 32'd0);
        check({tag, "_mult"}, 32'(multipla), 32'd0);
        check({tag, "_estado"}, 32'(db_estado), 32'd0);
    endtask

    initial begin
        int unsigned p;
        int unsigned seen;
        int unsigned tem_base;

        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        #1 reset = 1'b1;

        // Single clean press: accepted on the 11th edge counting the sampling edge
        @(negedge clock);
        botoes = 9'b000010000; habilita = 1'b1;
        p = cyc + 1;
        wait_tem(19, seen);
        check("latency_press", seen, p + DEB + 2);
        hold('0, 1'b1, 10);
        check("press5_jogada", 32'(jogada), 32'h010);
        check("press5_idx", 32'(jogada_idx), 32'd5);

        // Short glitch is ignored and the FSM returns to idle
        hold(9'b000000001, 1'b1, 5);
        hold('0, 1'b1, 10);
        check("glitch_idx", 32'(jogada_idx), 32'd5);
        check("glitch_estado", 32'(db_estado), 32'd0);

        // Two buttons: rejected, then a single press is accepted
        hold(9'b000000011, 1'b1, 20);
        hold('0, 1'b1, 10);
        check("multi_idx_kept", 32'(jogada_idx), 32'd5);
        hold(9'b000000010, 1'b1, 20);
        hold('0, 1'b1, 10);
        check("after_multi_idx", 32'(jogada_idx), 32'd2);
        check("after_multi_jogada", 32'(jogada), 32'h002);

        // Release bounce does not produce a second move
        tem_base = n_tem;
        hold(9'b000000100, 1'b1, 20);
        hold('0, 1'b1, 3);
        hold(9'b000000100, 1'b1, 20);
        hold('0, 1'b1, 10);
        check("bounce_one_move", n_tem - tem_base, 32'd1);
        hold(9'b000000100, 1'b1, 20);
        hold('0, 1'b1, 10);
        check("bounce_then_new", n_tem - tem_base, 32'd2);
        check("bounce_idx", 32'(jogada_idx), 32'd3);

        // Disabled press is discarded, enabled press is accepted
        hold(9'b000100000, 1'b0, 20);
        hold('0, 1'b1, 10);
        check("disabled_idx", 32'(jogada_idx), 32'd3);
        check("disabled_jogada", 32'(jogada), 32'h004);
        hold(9'b000100000, 1'b1, 20);
        hold('0, 1'b1, 10);
        check("enabled_idx", 32'(jogada_idx), 32'd6);

        // Reset mid-filter, with the button still held afterwards
        @(negedge clock);
        botoes = 9'b010000000; habilita = 1'b1;
        repeat (7) @(negedge clock);
        check("midfilter_estado", 32'(db_estado), 32'd1);
        #1 reset = 1'b0;
        #1 check_zero_outputs("async_reset");
        sb.delete();
        exp_jog = '0;
        exp_idx = '0;
        @(negedge clock);
        #1 reset = 1'b1;
        p = cyc + 1;
        wait_tem(19, seen);
        check("latency_after_reset", seen, p + DEB + 2);
        check("after_reset_idx", 32'(jogada_idx), 32'd8);
        hold('0, 1'b1, 10);

        // Random segments against the reference model
        for (int s = 0; s < 80; s++) begin
            int unsigned r;
            logic [8:0]  v;
            logic        h;
            int unsigned n;
            r = $urandom_range(0, 9);
            if (r < 4)      v = '0;
            else if (r < 8) v = 9'(1 << $urandom_range(0, 8));
            else            v = 9'($urandom_range(1, 511));
            h = ($urandom_range(0, 4) != 0);
            n = $urandom_range(1, 14);
            hold(v, h, n);
        end
        hold('0, 1'b1, 30);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
